// File: rtl/tcs3200_rgb_meas_pkg.sv
// Shared definitions for the TCS3200 colour measurement block.
// Contents: the frame FSM state encoding, the photodiode filter codes
// driven on {s2,s3}, the 8-bit normalisation scale and the debug record
// the top exposes for checkers.
package tcs3200_rgb_meas_pkg;

  typedef enum logic [3:0] {
    ST_SET_R,
    ST_GATE_R,
    ST_SET_G,
    ST_GATE_G,
    ST_SET_B,
    ST_GATE_B,
    ST_DIV_R,
    ST_DIV_G,
    ST_DIV_B,
    ST_PUB
  } state_t;

  // Filter select codes as {s2,s3}
  localparam logic [1:0] FILT_R = 2'b00;
  localparam logic [1:0] FILT_G = 2'b11;
  localparam logic [1:0] FILT_B = 2'b01;

  // Full-scale value of a normalised channel
  localparam logic [7:0] SCALE = 8'd255;

  typedef struct packed {
    state_t state;
    logic   div_busy;
    logic   cal_pending;
    logic   cal_frame;
  } dbg_t;

endpackage

// File: rtl/tcs3200_rgb_meas_if.sv
// RGB result bus from the colour front end to its consumer.
// Signals: data_r/g/b (8-bit normalised channels), data_valid (strobe),
// cal_done (strobe).
// Handshake: data_valid is a one-cycle strobe with no back-pressure (there
// is no ready); data_r/g/b change only in the strobe cycle and hold until
// the next strobe; cal_done is only ever high together with data_valid.
interface tcs3200_rgb_meas_if;
  logic [7:0] data_r;
  logic [7:0] data_g;
  logic [7:0] data_b;
  logic       data_valid;
  logic       cal_done;

  modport master (output data_r, data_g, data_b, data_valid, cal_done);
  modport slave  (input  data_r, data_g, data_b, data_valid, cal_done);
endinterface

// File: rtl/tcs3200_rgb_meas_rgb_div_seq.sv
// Sequential restoring divider used to normalise one colour channel.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   start              : one-cycle request; num/den sampled in this cycle
//   num                : CNT_W+8 bit dividend (count * 255)
//   den                : CNT_W bit divisor (white reference, never 0)
//   busy               : iterations in progress
//   done               : one-cycle pulse, quot valid in this cycle
//   quot               : 8-bit quotient, clamped to 255
// One quotient bit per cycle. The first bit is produced on the start edge,
// so done is high CNT_W+8 cycles after start and a caller that raises start
// on entry to a state and leaves on done spends exactly CNT_W+9 cycles there.
// The latency is the same whether or not the result saturates.
module rgb_div_seq #(
  parameter int CNT_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic [CNT_W+7:0]   num,
  input  logic [CNT_W-1:0]   den,
  output logic               busy,
  output logic               done,
  output logic [7:0]         quot
);

  localparam int NW   = CNT_W + 8;
  localparam int IT_W = $clog2(NW + 1);

  logic [CNT_W-1:0] rem;
  logic [NW-1:0]    sr;     // dividend bits shift out the top, quotient bits shift in
  logic [CNT_W-1:0] den_q;
  logic [IT_W-1:0]  iter;

  function automatic logic [CNT_W+NW-1:0] step(input logic [CNT_W-1:0] r,
                                               input logic [NW-1:0]    s,
                                               input logic [CNT_W-1:0] d);
    logic [CNT_W:0]   sh;
    logic             qb;
    logic [CNT_W-1:0] r_n;
    sh  = {r, s[NW-1]};
    qb  = (sh >= {1'b0, d});
    r_n = qb ? CNT_W'(sh - {1'b0, d}) : sh[CNT_W-1:0];
    return {r_n, s[NW-2:0], qb};
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rem   <= '0;
      sr    <= '0;
      den_q <= '0;
      iter  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, sr} <= step('0, num, den);
        den_q     <= den;
        iter      <= IT_W'(1);
        busy      <= 1'b1;
      end else if (busy) begin
        {rem, sr} <= step(rem, sr, den_q);
        iter      <= iter + IT_W'(1);
        if (iter == IT_W'(NW - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // count >= white gives a quotient of 255 or more; clamp to full scale
  assign quot = ((sr[NW-1:8] != '0) || (&sr[7:0])) ? 8'hFF : sr[7:0];

endmodule

// File: rtl/tcs3200_rgb_meas.sv
// TCS3200 colour sensor front end.
// Steps the photodiode filter through R, G, B, counts sensor edges in a
// fixed gate per channel, normalises each count to 8 bits against a white
// reference and publishes a coherent RGB triple.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   sensor_out         : TCS3200 OUT, asynchronous square wave
//   cal_white          : one-cycle pulse, capture white on the next frame
//   s0, s1             : frequency scaling select (fixed 20 %)
//   s2, s3             : filter select
//   rgb                : result bus (data_r/g/b, data_valid, cal_done)
//   dbg                : FSM state and internal flags for observation
module tcs3200_rgb_meas
  import tcs3200_rgb_meas_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int GATE_MS       = 10,
  parameter int SETTLE_CYC    = 50_000,
  parameter int CNT_W         = 16,
  parameter int WHITE_DEFAULT = 1000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      sensor_out,
  input  logic                      cal_white,
  output logic                      s0,
  output logic                      s1,
  output logic                      s2,
  output logic                      s3,
  tcs3200_rgb_meas_if.master        rgb,
  output dbg_t                      dbg
);

  localparam int GATE_CYC = CLK_FREQ / 1000 * GATE_MS;
  localparam int TMR_MAX  = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int NW       = CNT_W + 8;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] WHITE_INIT  = CNT_W'(WHITE_DEFAULT);

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       sens_sync;
  logic             rise;
  logic [1:0]       filt;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, cnt_b_nxt;
  logic [CNT_W-1:0] white_r, white_g, white_b;
  logic             pending, cal_frame;
  logic [7:0]       q_r, q_g;
  logic [7:0]       data_r, data_g, data_b;
  logic             data_valid, cal_done;
  logic             div_start, div_busy, div_done;
  logic [7:0]       div_quot;
  logic [CNT_W-1:0] div_cnt, div_den;
  logic [NW-1:0]    div_num;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A dead channel would otherwise give a zero divisor
  function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_W'(1) : c;
  endfunction

  // Two synchroniser flops, third flop for rising-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sens_sync <= '0;
    else            sens_sync <= {sens_sync[1:0], sensor_out};
  end
  assign rise = sens_sync[1] & ~sens_sync[2];

  // Blue count including an edge on the last gate cycle, so a white capture
  // on that same edge sees the complete count
  assign cnt_b_nxt = (state == ST_GATE_B && rise) ? sat_inc(cnt_b) : cnt_b;

  always_comb begin
    div_cnt = cnt_r;
    div_den = white_r;
    case (state)
      ST_DIV_G: begin div_cnt = cnt_g; div_den = white_g; end
      ST_DIV_B: begin div_cnt = cnt_b; div_den = white_b; end
      default:  ;
    endcase
  end
  assign div_num = NW'(div_cnt) * NW'(SCALE);

  rgb_div_seq #(.CNT_W(CNT_W)) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (div_start),
    .num       (div_num),
    .den       (div_den),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_SET_R;
      tmr        <= '0;
      filt       <= FILT_R;
      cnt_r      <= '0;
      cnt_g      <= '0;
      cnt_b      <= '0;
      white_r    <= WHITE_INIT;
      white_g    <= WHITE_INIT;
      white_b    <= WHITE_INIT;
      pending    <= 1'b0;
      cal_frame  <= 1'b0;
      q_r        <= '0;
      q_g        <= '0;
      data_r     <= '0;
      data_g     <= '0;
      data_b     <= '0;
      data_valid <= 1'b0;
      cal_done   <= 1'b0;
      div_start  <= 1'b0;
    end else begin
      div_start  <= 1'b0;
      data_valid <= 1'b0;
      cal_done   <= 1'b0;
      if (cal_white) pending <= 1'b1;

      case (state)
        ST_SET_R, ST_SET_G, ST_SET_B: begin
          if (state == ST_SET_R) cnt_r <= '0;
          if (state == ST_SET_G) cnt_g <= '0;
          if (state == ST_SET_B) cnt_b <= '0;
          if (tmr == SETTLE_LAST) begin
            tmr <= '0;
            state <= (state == ST_SET_R) ? ST_GATE_R :
                     (state == ST_SET_G) ? ST_GATE_G : ST_GATE_B;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_GATE_R: begin
          if (rise) cnt_r <= sat_inc(cnt_r);
          if (tmr == GATE_LAST) begin
            tmr   <= '0;
            filt  <= FILT_G;
            state <= ST_SET_G;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_GATE_G: begin
          if (rise) cnt_g <= sat_inc(cnt_g);
          if (tmr == GATE_LAST) begin
            tmr   <= '0;
            filt  <= FILT_B;
            state <= ST_SET_B;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_GATE_B: begin
          cnt_b <= cnt_b_nxt;
          if (tmr == GATE_LAST) begin
            tmr       <= '0;
            state     <= ST_DIV_R;
            div_start <= 1'b1;
            if (cal_frame) begin
              white_r <= max1(cnt_r);
              white_g <= max1(cnt_g);
              white_b <= max1(cnt_b_nxt);
            end
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_DIV_R: if (div_done) begin
          q_r       <= div_quot;
          div_start <= 1'b1;
          state     <= ST_DIV_G;
        end
        ST_DIV_G: if (div_done) begin
          q_g       <= div_quot;
          div_start <= 1'b1;
          state     <= ST_DIV_B;
        end
        ST_DIV_B: if (div_done) begin
          data_r     <= q_r;
          data_g     <= q_g;
          data_b     <= div_quot;
          data_valid <= 1'b1;
          cal_done   <= cal_frame;
          state      <= ST_PUB;
        end
        ST_PUB: begin
          // A request landing on this very edge is kept for the frame after
          filt      <= FILT_R;
          cal_frame <= pending;
          pending   <= cal_white;
          state     <= ST_SET_R;
        end
        default: state <= ST_SET_R;
      endcase
    end
  end

  assign s0 = 1'b1;
  assign s1 = 1'b0;
  assign {s2, s3} = filt;

  assign rgb.data_r     = data_r;
  assign rgb.data_g     = data_g;
  assign rgb.data_b     = data_b;
  assign rgb.data_valid = data_valid;
  assign rgb.cal_done   = cal_done;

  assign dbg = '{state: state, div_busy: div_busy, cal_pending: pending, cal_frame: cal_frame};

endmodule
